fp32_div_seq: RTL and testbench
===============================

Name: fp32_div_seq

Overview:
- Iterative IEEE-754 single-precision divider (result = data1 / data2); the sequential counterpart to the FPU's combinational multiplier.
- Uses a radix-2 restoring mantissa loop and round-to-nearest-even.
- A start/done handshake lets the FPU issue logic hold operands for one cycle only and collect the result later.
- Subnormals are flushed to zero on input and output, matching the multiplier's datapath scope.

Parameters:
- None. The format is fixed at FP32: 1 sign bit, 8 exponent bits, bias 127, 23 fraction bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- data1  in  32  dividend; captured on the accepted start edge
- data2  in  32  divisor; captured on the accepted start edge
- busy  out  1  high from the accept edge until done
- done  out  1  one-cycle pulse; result and flags are valid from this cycle
- result  out  32  quotient; holds until the next done
- dz  out  1  divide-by-zero flag; same timing as result
- nv  out  1  invalid-operation flag; same timing as result

Behaviour:
- Reset (async, while rst=1): FSM goes to IDLE; busy=0, done=0, result=0, dz=0, nv=0; internal registers are cleared.
  - Reset asserted mid-operation aborts the operation; no done is generated afterwards.
- FSM states: IDLE, ITER, ROUND, FIN.
  - IDLE, start=1 at an edge: latch operands, busy=1, classify operands.
    - Special case: go to FIN.
    - Normal case: go to ITER with cnt=0.
  - ITER: one quotient bit per cycle for 26 cycles (cnt 0..25), then go to ROUND.
  - ROUND: normalise, round, and pack the result; go to FIN.
  - FIN: done=1, busy=0, result and flags update; go to IDLE.
    - FIN always lasts exactly one cycle.
    - A new start is accepted on the edge that leaves FIN only if the FSM is back in IDLE, i.e. on the following edge.
- start is ignored while busy=1; operands may change freely after the accept edge.
- Latency, with the accept edge numbered 0:
  - special operands: done is high in the cycle after edge 1;
  - normal operands: done is high in the cycle after edge 28.
- Classification (exp field = 0 is treated as zero; the fraction is ignored):
  - Any NaN operand: result is data1 if data1 is NaN, else data2, with bit 22 forced to 1. Example: 0xFFFFFFFF propagates unchanged.
  - 0/0 or inf/inf: result = 0x7FC00000, nv=1.
  - finite nonzero / 0: result = signed infinity, dz=1.
  - inf / finite: result = signed infinity.
  - finite / inf, or 0 / nonzero: result = signed zero.
  - In every case sign = s1 XOR s2, except for NaN outputs.
- Normal path:
  - ma = {1,f1}, mb = {1,f2}; rem initialised to ma.
  - Each ITER step: if rem >= mb then qbit=1 and rem -= mb, else qbit=0. Then rem <<= 1, and q = {q[24:0], qbit}.
  - If q[25]=1: mantissa = q[25:2], guard = q[1], sticky = q[0] | (rem != 0), exponent = e1 - e2 + 127.
  - Otherwise: mantissa = q[24:1], guard = q[0], sticky = (rem != 0), exponent = e1 - e2 + 126.
  - Exponent arithmetic is signed 10-bit.
  - Rounding is RNE: increment when guard & (sticky | lsb). A carry out of the mantissa gives mantissa = 1.0 and exponent + 1.
  - Exponent >= 255 after rounding: result = signed infinity (0x7F800000 or 0xFF800000).
  - Exponent <= 0: result = signed zero.
- Flags are cleared on every accepted start and hold until the next done.

Test Plan:
- 0x40C00000 / 0x3FC00000 (6.0 / 1.5) -> result 0x40800000, dz=0, nv=0, done exactly 28 cycles after the accept edge, busy high for 28 cycles.
- 0x3F800000 / 0x40400000 (1/3), then 0xC1200000 / 0x40800000 (-10 / 4) issued back-to-back -> 0x3EAAAAAB (RNE round-up), then 0xC0200000.
- 0x40ACCCCD / 0x00000000 -> 0x7F800000, dz=1, done 1 cycle after accept; 0x00000000 / 0x80000000 -> 0x7FC00000, nv=1; 0x40ACCCCD / 0xFFFFFFFF -> 0xFFFFFFFF.
- 0x7F7FFFFF / 0x3F000000 (max / 0.5) -> 0x7F800000; 0x00800000 / 0x40000000 -> 0x00000000 (flush to zero).
- Hold start=1 for 40 cycles with operands changing after accept -> exactly one done, carrying the result of the operands latched at the accept edge.
- Assert rst at cycle 10 of ITER -> busy, done, result and flags go to 0 immediately and no done follows; a fresh 6.0 / 1.5 afterwards -> 0x40800000.

Source files
------------

// File: rtl/fp32_div_seq_if.sv
// Handshake and operand/result bundle for the sequential FP32 divider.
// The issuing side uses the master modport; the divider uses the slave modport.
interface fp32_div_seq_if;
   logic        start;
   logic [31:0] data1;
   logic [31:0] data2;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        dz;
   logic        nv;

   modport master (output start, data1, data2, input busy, done, result, dz, nv);
   modport slave  (input start, data1, data2, output busy, done, result, dz, nv);
endinterface

// File: rtl/fp32_div_seq.sv
// Iterative IEEE-754 single-precision divider: radix-2 restoring mantissa loop,
// round-to-nearest-even, subnormals flushed to zero on input and output.
module fp32_div_seq (
   input logic           clk,
   input logic           rst,
   fp32_div_seq_if.slave bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ITER  = 2'd1;
   localparam logic [1:0] ROUND = 2'd2;
   localparam logic [1:0] FIN   = 2'd3;

   logic [1:0]        state;
   logic [4:0]        cnt;
   logic              sgn;
   logic signed [9:0] exp_b;
   logic [23:0]       mb;
   logic [24:0]       rem;
   logic [25:0]       q;
   logic [31:0]       res_r;
   logic              dz_r;
   logic              nv_r;

   logic [7:0]  e1, e2;
   logic [22:0] f1, f2;
   logic        nan1, nan2, inf1, inf2, zero1, zero2, s_in;
   logic        spec, spec_dz, spec_nv;
   logic [31:0] spec_res;

   assign e1    = bus.data1[30:23];
   assign e2    = bus.data2[30:23];
   assign f1    = bus.data1[22:0];
   assign f2    = bus.data2[22:0];
   assign nan1  = (e1 == 8'hFF) && (f1 != '0);
   assign nan2  = (e2 == 8'hFF) && (f2 != '0);
   assign inf1  = (e1 == 8'hFF) && (f1 == '0);
   assign inf2  = (e2 == 8'hFF) && (f2 == '0);
   assign zero1 = (e1 == '0);
   assign zero2 = (e2 == '0);
   assign s_in  = bus.data1[31] ^ bus.data2[31];

   // Priority order matters: inf/0 is plain infinity, not divide-by-zero.
   always_comb begin
      spec     = 1'b1;
      spec_res = '0;
      spec_dz  = 1'b0;
      spec_nv  = 1'b0;
      if (nan1)
         spec_res = {bus.data1[31:23], 1'b1, bus.data1[21:0]};
      else if (nan2)
         spec_res = {bus.data2[31:23], 1'b1, bus.data2[21:0]};
      else if ((zero1 && zero2) || (inf1 && inf2)) begin
         spec_res = 32'h7FC0_0000;
         spec_nv  = 1'b1;
      end else if (inf1)
         spec_res = {s_in, 8'hFF, 23'd0};
      else if (zero2) begin
         spec_res = {s_in, 8'hFF, 23'd0};
         spec_dz  = 1'b1;
      end else if (inf2 || zero1)
         spec_res = {s_in, 31'd0};
      else
         spec = 1'b0;
   end

   logic [23:0]       mant;
   logic              guard, sticky;
   logic signed [9:0] exp_n, exp_f;
   logic [24:0]       mant_r;
   logic [31:0]       packed_res;

   always_comb begin
      if (q[25]) begin
         mant   = q[25:2];
         guard  = q[1];
         sticky = q[0] | (rem != '0);
         exp_n  = exp_b;
      end else begin
         mant   = q[24:1];
         guard  = q[0];
         sticky = (rem != '0);
         exp_n  = exp_b - 10'sd1;
      end
      mant_r = {1'b0, mant} + {24'd0, guard & (sticky | mant[0])};
      // A rounding carry leaves mant_r[22:0] zero, i.e. mantissa 1.0.
      exp_f  = mant_r[24] ? exp_n + 10'sd1 : exp_n;
      if (exp_f >= 10'sd255)
         packed_res = {sgn, 8'hFF, 23'd0};
      else if (exp_f <= 10'sd0)
         packed_res = {sgn, 31'd0};
      else
         packed_res = {sgn, exp_f[7:0], mant_r[22:0]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         sgn        <= 1'b0;
         exp_b      <= '0;
         mb         <= '0;
         rem        <= '0;
         q          <= '0;
         res_r      <= '0;
         dz_r       <= 1'b0;
         nv_r       <= 1'b0;
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
         bus.result <= '0;
         bus.dz     <= 1'b0;
         bus.nv     <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  bus.busy <= 1'b1;
                  bus.dz   <= 1'b0;
                  bus.nv   <= 1'b0;
                  sgn      <= s_in;
                  exp_b    <= $signed({2'b00, e1}) - $signed({2'b00, e2}) + 10'sd127;
                  mb       <= {1'b1, f2};
                  rem      <= {2'b01, f1};
                  q        <= '0;
                  cnt      <= '0;
                  res_r    <= spec_res;
                  dz_r     <= spec_dz;
                  nv_r     <= spec_nv;
                  state    <= spec ? FIN : ITER;
               end
            end
            ITER: begin
               if (rem >= {1'b0, mb}) begin
                  rem <= (rem - {1'b0, mb}) << 1;
                  q   <= {q[24:0], 1'b1};
               end else begin
                  rem <= rem << 1;
                  q   <= {q[24:0], 1'b0};
               end
               cnt <= cnt + 5'd1;
               if (cnt == 5'd25)
                  state <= ROUND;
            end
            ROUND: begin
               res_r <= packed_res;
               state <= FIN;
            end
            default: begin
               bus.done   <= 1'b1;
               bus.busy   <= 1'b0;
               bus.result <= res_r;
               bus.dz     <= dz_r;
               bus.nv     <= nv_r;
               state      <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fp32_div_seq.sv
// Self-checking bench for fp32_div_seq: directed vector table, randomized ops
// against an arithmetic reference model, start-hold and mid-run reset sequences.
module tb_fp32_div_seq;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fp32_div_seq_if bus ();
   fp32_div_seq dut (.clk(clk), .rst(rst), .bus(bus));

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        dz;
      logic        nv;
      int          lat;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference: classification rules, then exact integer quotient of the mantissas.
   function automatic vec_t model(input logic [31:0] a, input logic [31:0] b);
      vec_t        v;
      logic [7:0]  ea, eb;
      logic [22:0] fa, fb;
      logic        s, nana, nanb, infa, infb, za, zb, g, st;
      logic [63:0] num, den, qt, rm, mant;
      int          e;
      ea = a[30:23]; eb = b[30:23]; fa = a[22:0]; fb = b[22:0];
      s = a[31] ^ b[31];
      nana = (ea == 8'hFF) && (fa != 0); nanb = (eb == 8'hFF) && (fb != 0);
      infa = (ea == 8'hFF) && (fa == 0); infb = (eb == 8'hFF) && (fb == 0);
      za = (ea == 0); zb = (eb == 0);
      v.a = a; v.b = b; v.dz = 1'b0; v.nv = 1'b0; v.lat = 1;
      if (nana)                             v.res = a | 32'h0040_0000;
      else if (nanb)                        v.res = b | 32'h0040_0000;
      else if ((za && zb) || (infa && infb)) begin v.res = 32'h7FC0_0000; v.nv = 1'b1; end
      else if (infa)                        v.res = {s, 8'hFF, 23'd0};
      else if (zb) begin                    v.res = {s, 8'hFF, 23'd0}; v.dz = 1'b1; end
      else if (infb || za)                  v.res = {s, 31'd0};
      else begin
         v.lat = 28;
         num = {40'd0, 1'b1, fa} << 26;
         den = {40'd0, 1'b1, fb};
         qt = num / den;
         rm = num % den;
         if (qt >= (64'd1 << 26)) begin
            mant = qt >> 3; g = qt[2]; st = (qt[1:0] != 0) || (rm != 0);
            e = int'(ea) - int'(eb) + 127;
         end else begin
            mant = qt >> 2; g = qt[1]; st = qt[0] || (rm != 0);
            e = int'(ea) - int'(eb) + 126;
         end
         if (g && (st || mant[0])) mant = mant + 1;
         if (mant == (64'd1 << 24)) begin mant = 64'd1 << 23; e = e + 1; end
         if (e >= 255)    v.res = {s, 8'hFF, 23'd0};
         else if (e <= 0) v.res = {s, 31'd0};
         else             v.res = {s, e[7:0], mant[22:0]};
      end
      return v;
   endfunction

   function automatic logic [31:0] rnd_op();
      logic [7:0]  e;
      logic [22:0] f;
      int          r;
      r = $urandom_range(0, 15);
      f = 23'($urandom);
      if (r == 0)      e = 8'h00;
      else if (r == 1) begin e = 8'hFF; if ($urandom_range(0, 1) == 1) f = '0; end
      else             e = 8'($urandom_range(1, 254));
      return {1'($urandom), e, f};
   endfunction

   function automatic logic [31:0] rnd_norm();
      return {1'($urandom), 8'($urandom_range(8'h70, 8'h8F)), 23'($urandom)};
   endfunction

   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic d, output logic n,
                         output int lat, output int bcyc);
      @(negedge clk);
      bus.start = 1'b1; bus.data1 = a; bus.data2 = b;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.data1 = $urandom; bus.data2 = $urandom;
      lat = 0;
      bcyc = bus.busy ? 1 : 0;
      while (!bus.done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
         if (bus.busy) bcyc++;
      end
      r = bus.result; d = bus.dz; n = bus.nv;
   endtask

   task automatic run_check(input string tag, input vec_t v);
      logic [31:0] r;
      logic        d, n;
      int          lat, bcyc;
      run_op(v.a, v.b, r, d, n, lat, bcyc);
      chk({tag, " result"}, 64'(r), 64'(v.res));
      chk({tag, " dz"}, 64'(d), 64'(v.dz));
      chk({tag, " nv"}, 64'(n), 64'(v.nv));
      chk({tag, " latency"}, 64'(lat), 64'(v.lat));
      chk({tag, " busy cycles"}, 64'(bcyc), 64'(v.lat));
   endtask

   initial begin
      int          dcount, w;
      logic [31:0] hres;
      vec_t        v;

      rst = 1'b1; bus.start = 1'b0; bus.data1 = '0; bus.data2 = '0;
      repeat (2) @(posedge clk);
      #1 chk("reset outputs", 64'({bus.busy, bus.done, bus.result, bus.dz, bus.nv}), 64'd0);
      @(negedge clk) rst = 1'b0;

      vecs[0]  = '{32'h40C00000, 32'h3FC00000, 32'h40800000, 1'b0, 1'b0, 28};
      vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0, 28};
      vecs[2]  = '{32'hC1200000, 32'h40800000, 32'hC0200000, 1'b0, 1'b0, 28};
      vecs[3]  = '{32'h40ACCCCD, 32'h00000000, 32'h7F800000, 1'b1, 1'b0, 1};
      vecs[4]  = '{32'h00000000, 32'h80000000, 32'h7FC00000, 1'b0, 1'b1, 1};
      vecs[5]  = '{32'h40ACCCCD, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1};
      vecs[6]  = '{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 1'b0, 1'b0, 28};
      vecs[7]  = '{32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 28};
      vecs[8]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b1, 1};
      vecs[9]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0, 1};
      vecs[10] = '{32'h3F800000, 32'hFF800000, 32'h80000000, 1'b0, 1'b0, 1};
      vecs[11] = '{32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1'b0, 1};
      vecs[12] = '{32'h7F800001, 32'h7F800002, 32'h7FC00001, 1'b0, 1'b0, 1};
      vecs[13] = '{32'h3F800000, 32'h7F800002, 32'h7FC00002, 1'b0, 1'b0, 1};
      vecs[14] = '{32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 1'b0, 1};
      vecs[15] = '{32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b0, 1};

      for (int i = 0; i < 16; i++)
         run_check($sformatf("vec%0d", i), vecs[i]);

      for (int i = 0; i < 40; i++) begin
         v = model(rnd_op(), rnd_op());
         run_check($sformatf("rand%0d %h/%h", i, v.a, v.b), v);
      end

      // start held high while operands change after the accept edge
      @(negedge clk);
      bus.start = 1'b1; bus.data1 = 32'h40C00000; bus.data2 = 32'h3FC00000;
      dcount = 0; hres = '0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.done) begin dcount++; hres = bus.result; end
         @(negedge clk);
         bus.data1 = rnd_norm(); bus.data2 = rnd_norm();
      end
      bus.start = 1'b0;
      chk("hold done count", 64'(dcount), 64'd1);
      chk("hold result", 64'(hres), 64'h40800000);
      w = 0;
      while (!bus.done && w < 100) begin @(posedge clk); #1; w++; end
      chk("hold drain", 64'(w < 100), 64'd1);

      // reset during ITER aborts the operation
      @(negedge clk);
      bus.start = 1'b1; bus.data1 = 32'h40C00000; bus.data2 = 32'h3FC00000;
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b1;
      #1 chk("midrun reset outputs", 64'({bus.busy, bus.done, bus.result, bus.dz, bus.nv}), 64'd0);
      @(negedge clk) rst = 1'b0;
      dcount = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.done) dcount++;
      end
      chk("no done after reset", 64'(dcount), 64'd0);
      run_check("post reset", vecs[0]);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
